instr_encode_loader: RTL

INSTR_ENCODE_LOADER -- requirements
Module: instr_encode_loader

---
 rtl/instr_encode_loader_pkg.sv | 26 ++
 rtl/instr_encoder.sv | 28 ++
 rtl/instr_encode_loader.sv | 117 +++++++++++
 3 files changed

// File: rtl/instr_encode_loader_pkg.sv
// rtl/instr_encode_loader_pkg.sv - shared CPU instruction fields, opcodes and loader state encoding
package instr_encode_loader_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 5;
  localparam int REG_W    = 4;
  localparam int ALU_W    = 5;
  localparam int LOW_W    = 15;

  // Field positions are shared with the decoder, so encode and decode stay exact inverses.
  localparam int OPCODE_LSB = 27;
  localparam int RD_LSB     = 23;
  localparam int RS_LSB     = 19;
  localparam int RT_LSB     = 15;
  localparam int LOW_LSB    = 0;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 5'b00000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_FULL  = 2'd3
  } load_state_t;

endpackage

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - combinational packing of instruction fields into one word
module instr_encoder
  import instr_encode_loader_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [ALU_W-1:0]    alu_control,
  input  logic [REG_W-1:0]    rd,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [LOW_W-1:0]    imm,
  output logic [INSTR_W-1:0]  word
);

  always_comb begin
    word = '0;
    word[OPCODE_LSB +: OPCODE_W] = opcode;
    word[RD_LSB +: REG_W]        = rd;
    word[RS_LSB +: REG_W]        = rs;
    word[RT_LSB +: REG_W]        = rt;
    // R-type carries the ALU function zero-extended in the low field; others carry imm.
    if (opcode == OP_RTYPE) begin
      word[LOW_LSB +: ALU_W] = alu_control;
    end else begin
      word[LOW_LSB +: LOW_W] = imm;
    end
  end

endmodule

// File: rtl/instr_encode_loader.sv
// rtl/instr_encode_loader.sv - encodes instruction fields and writes them into instruction memory
module instr_encode_loader
  import instr_encode_loader_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [4:0]          opcode,
  input  logic [4:0]          alu_control,
  input  logic [3:0]          rd,
  input  logic [3:0]          rs,
  input  logic [3:0]          rt,
  input  logic [14:0]         imm,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [ADDR_W:0]     count,
  output logic                done,
  output logic                overflow
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  load_state_t        state_q, state_d;
  logic [31:0]        enc_word;
  logic [ADDR_W:0]    count_q;
  logic [ADDR_W:0]    count_inc;
  logic               last_q;
  logic               overflow_q;
  logic               xfer;

  instr_encoder u_encoder (
    .opcode      (opcode),
    .alu_control (alu_control),
    .rd          (rd),
    .rs          (rs),
    .rt          (rt),
    .imm         (imm),
    .word        (enc_word)
  );

  assign count_inc = count_q + ONE;
  // clear wins over a simultaneous handshake, so the transfer is simply dropped.
  assign xfer      = in_valid && (state_q == ST_IDLE) && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (xfer) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we = 1'b1;
        if (last_q)                  state_d = ST_DONE;
        else if (count_inc == DEPTH) state_d = ST_FULL;
        else                         state_d = ST_IDLE;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      ST_FULL: begin
        state_d = ST_FULL;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      count_q    <= '0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // Address and word are latched at the handshake and held until the next one.
      if (xfer) begin
        mem_wdata <= enc_word;
        mem_addr  <= count_q[ADDR_W-1:0];
        last_q    <= in_last;
      end
      if (state_q == ST_WRITE) begin
        count_q <= count_inc;
      end
      if ((state_q == ST_FULL) && in_valid) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
